// File: rtl/sipo_pkg.sv
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types, state encodings and the parity helper used by
//               the serial-to-parallel receive controller.
//               The PARITY state is only reachable when PARITY_CHECK_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

    // Default number of data bits per word
    localparam int WIDTH_DEF = 4;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } sipo_state_e;

    // State encodings as plain constants for use in the state register
    localparam logic [1:0] ST_IDLE   = 2'(S_IDLE);
    localparam logic [1:0] ST_SHIFT  = 2'(S_SHIFT);
    localparam logic [1:0] ST_PARITY = 2'(S_PARITY);

    // Even parity holds when data plus parity bit has an even number of ones.
    // Data narrower than 32 bits is zero-extended, which does not change parity.
    function automatic logic even_parity_ok(input logic [31:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// ============================================================================
// Module      : sipo_shift_reg
// Description : WIDTH-bit serial-in parallel-out shift register. New bits
//               enter at the MSB and move toward bit 0. The first bit lands
//               at [0] once WIDTH bits have been shifted in. Synchronous
//               clear has priority over shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: clear, shift in at MSB, or hold
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (shift_en) begin
            data_d = {bit_in, data_q[WIDTH-1:1]};
        end
    end

    // Register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
// ============================================================================
// Module      : sipo_rx_ctrl
// Description : Frames a serial bit stream into WIDTH-bit words. Handles
//               start detection and bit counting, captures words into a
//               holding register, performs the valid/ready hand-off to the
//               consumer, and keeps sticky overrun and framing error flags.
//               Optional feature macro: PARITY_CHECK_EN. When it is defined,
//               an even-parity bit follows the data bits and the par_err
//               port is added.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_start,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             ovr_err,
    output logic             frm_err,
`ifdef PARITY_CHECK_EN
    output logic             par_err,
`endif
    input  logic             err_clr
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             ovr_q, ovr_d;
    logic             frm_q, frm_d;
    logic             par_q, par_d;

    logic             sr_clr;
    logic             sr_en;
    logic [WIDTH-1:0] sr_data;
    logic             last_bit;
    logic             complete;
    logic [WIDTH-1:0] word_val;
    logic             word_ok;
    logic             load;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .clr      (sr_clr),
        .shift_en (sr_en),
        .bit_in   (sin_data),
        .data     (sr_data)
    );

    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    // The cycle that finishes a frame, plus the word it yields and whether it is acceptable
`ifdef PARITY_CHECK_EN
    assign complete = (state_q == ST_PARITY) && sin_valid && !abort;
    assign word_val = sr_data;
    assign word_ok  = even_parity_ok(32'(sr_data), sin_data);
`else
    assign complete = (state_q == ST_SHIFT) && sin_valid && last_bit && !abort;
    assign word_val = {sin_data, sr_data[WIDTH-1:1]};
    assign word_ok  = 1'b1;
`endif

    // The holding register can take a word if it is empty or being drained this cycle
    assign load = complete && word_ok && (!out_valid_q || out_ready);

    // FSM, bit counter and shift-register control
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sr_clr  = 1'b0;
        sr_en   = 1'b0;
        frm_d   = frm_q;
        case (state_q)
            ST_IDLE: begin
                if (!abort && sin_start) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                    sr_clr  = 1'b1;
                end
            end
            ST_SHIFT, ST_PARITY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    sr_clr  = 1'b1;
                end else if (complete) begin
                    // A start on the completing bit opens the next frame immediately
                    state_d = sin_start ? ST_SHIFT : ST_IDLE;
                    count_d = '0;
                    sr_clr  = 1'b1;
                end else if (sin_start) begin
                    frm_d   = 1'b1;
                    state_d = ST_SHIFT;
                    count_d = '0;
                    sr_clr  = 1'b1;
                end else if (sin_valid && (state_q == ST_SHIFT)) begin
                    sr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
`ifdef PARITY_CHECK_EN
                    // All data bits are in; the count parks at WIDTH while the parity bit is awaited
                    if (last_bit) begin
                        state_d = ST_PARITY;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                sr_clr  = 1'b1;
            end
        endcase
        if (err_clr) begin
            frm_d = 1'b0;
        end
    end

    // Holding register, handshake and the remaining sticky flags
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovr_d       = ovr_q;
        par_d       = par_q;
        if (load) begin
            out_data_d  = word_val;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (complete && word_ok && !load) begin
            ovr_d = 1'b1;
        end
        if (complete && !word_ok) begin
            par_d = 1'b1;
        end
        if (err_clr) begin
            ovr_d = 1'b0;
            par_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovr_q       <= 1'b0;
            frm_q       <= 1'b0;
            par_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovr_q       <= ovr_d;
            frm_q       <= frm_d;
            par_q       <= par_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign ovr_err   = ovr_q;
    assign frm_err   = frm_q;
`ifdef PARITY_CHECK_EN
    assign par_err   = par_q;
`else
    // Parity flag has no observer without the parity feature
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
// ============================================================================
// Module      : tb_sipo_rx_ctrl
// Description : Self-checking bench for sipo_rx_ctrl (WIDTH=4). Directed
//               scenarios plus randomized traffic checked against a
//               frame-level reference model. Honours PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_rx_ctrl;

    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sin_start, sin_valid, sin_data, abort, out_ready, err_clr;
    logic         out_valid, busy, ovr_err, frm_err;
    logic [W-1:0] out_data;
`ifdef PARITY_CHECK_EN
    logic         par_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame contents as a list of received bits
    logic         m_bits[$];
    logic         m_in;
    logic         m_ov;
    logic [W-1:0] m_data;
    logic         m_ovr, m_frm, m_par;

    sipo_rx_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_start (sin_start),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .ovr_err   (ovr_err),
        .frm_err   (frm_err),
`ifdef PARITY_CHECK_EN
        .par_err   (par_err),
`endif
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bits.delete();
        m_in = 0; m_ov = 0; m_data = '0; m_ovr = 0; m_frm = 0; m_par = 0;
    endtask

    // Advance the model by one clock using the frame rules
    task automatic model_step(input logic st, v, d, ab, rdy, clr);
        logic         drain;
        logic         loaded;
        logic [W-1:0] word;
        logic         ok;
        drain  = m_ov && rdy;
        loaded = 0;
        if (ab) begin
            m_in = 0;
            m_bits.delete();
        end else if (m_in) begin
            if (v && m_bits.size() == FL - 1) begin
                m_bits.push_back(d);
                ok = 1;
                for (int i = 0; i < W; i++) word[i] = m_bits[i];
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < FL; i++) ok = ok ^ m_bits[i];
`endif
                if (!ok) m_par = 1;
                else if (!m_ov || rdy) begin m_data = word; loaded = 1; end
                else m_ovr = 1;
                m_bits.delete();
                m_in = st;
            end else if (st) begin
                m_frm = 1;
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(d);
            end
        end else if (st) begin
            m_in = 1;
            m_bits.delete();
        end
        if (loaded) m_ov = 1;
        else if (drain) m_ov = 0;
        if (clr) begin m_ovr = 0; m_frm = 0; m_par = 0; end
    endtask

    // One clock of stimulus; returns 1 ns after the edge
    task automatic cyc(input logic st, v, d, ab, rdy, clr);
        sin_start = st; sin_valid = v; sin_data = d; abort = ab; out_ready = rdy; err_clr = clr;
        @(posedge clk);
        model_step(st, v, d, ab, rdy, clr);
        #1;
    endtask

    // Send one full frame body (data bits, plus parity bit when enabled)
    task automatic send_frame(input logic [W-1:0] w, input logic rdy, input logic st_last);
        for (int i = 0; i < W; i++) begin
`ifdef PARITY_CHECK_EN
            cyc(1'b0, 1'b1, w[i], 1'b0, rdy, 1'b0);
`else
            cyc((i == W - 1) ? st_last : 1'b0, 1'b1, w[i], 1'b0, rdy, 1'b0);
`endif
        end
`ifdef PARITY_CHECK_EN
        cyc(st_last, 1'b1, ^w, 1'b0, rdy, 1'b0);
`endif
    endtask

    task automatic test_reset();
        rst = 1; sin_start = 0; sin_valid = 0; sin_data = 0; abort = 0; out_ready = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_errors++; $display("FAIL reset_data got %b exp 0000", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if ({ovr_err, frm_err} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b exp 00", {ovr_err, frm_err}); end
        rst = 0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 0, 1, 0);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        send_frame(4'b1101, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        n_checks++; if (out_data !== 4'b1101) begin n_errors++; $display("FAIL basic_data got %b exp 1101", out_data); end
        cyc(0, 0, 0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_overrun();
        cyc(1, 0, 0, 0, 0, 0);
        send_frame(4'b1101, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        send_frame(4'b0110, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovr_valid got %b exp 1", out_valid); end
        n_checks++; if (out_data !== 4'b1101) begin n_errors++; $display("FAIL ovr_held got %b exp 1101", out_data); end
        n_checks++; if (ovr_err !== 1'b1) begin n_errors++; $display("FAIL ovr_set got %b exp 1", ovr_err); end
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++; if (ovr_err !== 1'b0) begin n_errors++; $display("FAIL ovr_clr got %b exp 0", ovr_err); end
        cyc(0, 0, 0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_frame_err();
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, 0);
        n_checks++; if (frm_err !== 1'b1) begin n_errors++; $display("FAIL frm_set got %b exp 1", frm_err); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL frm_busy got %b exp 1", busy); end
        send_frame(4'b0110, 1'b1, 1'b0);
        n_checks++; if (out_data !== 4'b0110) begin n_errors++; $display("FAIL frm_data got %b exp 0110", out_data); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL frm_valid got %b exp 1", out_valid); end
        cyc(0, 0, 0, 0, 1, 1);
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL frm_clr got %b exp 0", frm_err); end
    endtask

    task automatic test_abort();
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 1, 0);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle got %b exp 0", busy); end
        cyc(0, 1, 1, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_checks++; if ({ovr_err, frm_err} !== 2'b00) begin n_errors++; $display("FAIL abort_flags got %b exp 00", {ovr_err, frm_err}); end
    endtask

    task automatic test_reset_midframe();
        cyc(1, 0, 0, 0, 0, 0);
        send_frame(4'b1101, 1'b0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        #3 rst = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 4'b0000) begin n_errors++; $display("FAIL rstmid_data got %b exp 0000", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cyc(1, 0, 0, 0, 1, 0);
        send_frame(4'b1011, 1'b1, 1'b0);
        n_checks++; if (out_data !== 4'b1011) begin n_errors++; $display("FAIL rstmid_frame got %b exp 1011", out_data); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_fvalid got %b exp 1", out_valid); end
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 1, 0);
        send_frame(4'b1101, 1'b1, 1'b1);
        n_checks++; if (out_data !== 4'b1101) begin n_errors++; $display("FAIL b2b_first got %b exp 1101", out_data); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
        n_checks++; if (frm_err !== 1'b0) begin n_errors++; $display("FAIL b2b_frm got %b exp 0", frm_err); end
        send_frame(4'b0110, 1'b1, 1'b0);
        n_checks++; if (out_data !== 4'b0110) begin n_errors++; $display("FAIL b2b_second got %b exp 0110", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
        cyc(0, 0, 0, 0, 1, 0);
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0); cyc(0, 1, 0, 0, 1, 0); cyc(0, 1, 1, 0, 1, 0); cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0);
        n_checks++; if (out_data !== 4'b1101) begin n_errors++; $display("FAIL par_good got %b exp 1101", out_data); end
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0); cyc(0, 1, 0, 0, 1, 0); cyc(0, 1, 1, 0, 1, 0); cyc(0, 1, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL par_drop got %b exp 0", out_valid); end
        n_checks++; if (par_err !== 1'b1) begin n_errors++; $display("FAIL par_set got %b exp 1", par_err); end
        cyc(0, 0, 0, 0, 1, 1);
        n_checks++; if (par_err !== 1'b0) begin n_errors++; $display("FAIL par_clr got %b exp 0", par_err); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
                ($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 29) == 0));
            n_checks++; if (out_valid !== m_ov) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, out_valid, m_ov); end
            n_checks++; if (out_data !== m_data) begin n_errors++; $display("FAIL rnd_data cyc %0d got %b exp %b", n, out_data, m_data); end
            n_checks++; if (busy !== m_in) begin n_errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", n, busy, m_in); end
            n_checks++; if ({ovr_err, frm_err} !== {m_ovr, m_frm}) begin n_errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", n, {ovr_err, frm_err}, {m_ovr, m_frm}); end
`ifdef PARITY_CHECK_EN
            n_checks++; if (par_err !== m_par) begin n_errors++; $display("FAIL rnd_par cyc %0d got %b exp %b", n, par_err, m_par); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
